// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state encoding, strobe constants and strobe legality check
package dmem_responder_pkg;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   localparam logic [3:0] STRB_NONE    = 4'b0000;
   localparam logic [3:0] STRB_WORD    = 4'b1111;
   localparam logic [3:0] STRB_HALF_LO = 4'b0011;
   localparam logic [3:0] STRB_HALF_HI = 4'b1100;
   localparam logic [3:0] STRB_BYTE0   = 4'b0001;
   localparam logic [3:0] STRB_BYTE1   = 4'b0010;
   localparam logic [3:0] STRB_BYTE2   = 4'b0100;
   localparam logic [3:0] STRB_BYTE3   = 4'b1000;

   // a read is always legal; stores must be naturally aligned word, half or byte
   function automatic logic strb_legal(input logic [3:0] strb, input logic [1:0] off);
      return strb == STRB_NONE
          || (strb == STRB_WORD && off == 2'd0)
          || (strb == STRB_HALF_LO && off == 2'd0)
          || (strb == STRB_HALF_HI && off == 2'd2)
          || strb == (STRB_BYTE0 << off);
   endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: word RAM with four byte-lane write enables and a registered read port
module dmem_byte_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // lane-wise store; contents survive reset, only the read register clears
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (rst) rdata <= '0;
      else if (en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store data-memory responder; define DMEM_RESPONDER_ERR_EN for range/strobe error checking
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state, nxt;
   logic [3:0]    cnt;
   logic [AW-1:0] idx;
   logic [1:0]    off, sh;
   logic [3:0]    wstrb, ram_we;
   logic [31:0]   wdata, ram_rdata;
   logic          acc_err, err, err_r, rd_ok, ram_en;

`ifdef DMEM_RESPONDER_ERR_EN
   logic [32:0] rel;
   assign rel     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
   assign acc_err = rel >= (33'(DEPTH_WORDS) << 2) || !strb_legal(req_wstrb, req_addr[1:0]);
`else
   assign acc_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else state <= nxt;
   end

   // next state: idle -> (wait) -> access -> resp -> idle
   always_comb begin
      nxt = state == S_IDLE   ? (req_valid ? (WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS) : S_IDLE)
          : state == S_WAIT   ? (cnt == 4'd0 ? S_ACCESS : S_WAIT)
          : state == S_ACCESS ? S_RESP
          : S_IDLE;
   end

   // handshake and RAM controls decoded from state; an errored request never writes
   always_comb begin
      req_ready  = state == S_IDLE;
      resp_valid = state == S_RESP;
      ram_en     = state == S_ACCESS;
      ram_we     = (ram_en && !err) ? wstrb : STRB_NONE;
   end

   // request latch on accept, wait countdown, response qualifiers captured at the access edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         off   <= '0;
         wstrb <= '0;
         wdata <= '0;
         err   <= 1'b0;
         rd_ok <= 1'b0;
         err_r <= 1'b0;
         sh    <= '0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            idx   <= AW'((req_addr - BASE_ADDR) >> 2);
            off   <= req_addr[1:0];
            wstrb <= req_wstrb;
            wdata <= req_wdata;
            err   <= acc_err;
            cnt   <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (state == S_ACCESS) begin
            rd_ok <= wstrb == STRB_NONE && !err;
            err_r <= err;
            sh    <= off;
         end
      end
   end

   dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (idx),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   assign resp_rdata = rd_ok ? ram_rdata >> {sh, 3'b000} : '0;
   assign resp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized model-checked bench for two responders (0 and 3 wait states)
module tb_dmem_responder;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic            clk = 1'b0;
   logic [1:0]      rst, req_valid, req_ready, resp_valid, resp_err;
   logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
   logic [1:0][3:0]  req_wstrb;

   logic [31:0] mm [2][DEPTH];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) u1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   function automatic int wc(input int d);
      return d == 0 ? 0 : 3;
   endfunction

   function automatic logic legal(input logic [3:0] s, input int off);
      return s == 4'h0 || (s == 4'hF && off == 0) || (s == 4'h3 && off == 0)
          || (s == 4'hC && off == 2) || s == 4'(1 << off);
   endfunction

   task automatic model(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                        output logic [31:0] xr, output logic xe);
      logic [31:0] rel;
      int idx, off;
      rel = a - BASE;
      off = int'(a[1:0]);
      idx = int'(rel >> 2) % DEPTH;
      xe  = 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
      xe = (rel >= 32'(4 * DEPTH)) || !legal(s, off);
`endif
      xr = '0;
      if (!xe) begin
         if (s == 4'h0) xr = mm[d][idx] >> (8 * off);
         else for (int b = 0; b < 4; b++) if (s[b]) mm[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic do_req(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      logic [31:0] xr;
      logic xe;
      int g, n;
      model(d, a, s, wd, xr, xe);
      g = 0;
      while (req_ready[d] !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
      checks++;
      if (g == 50) begin errors++; $display("FAIL ready_timeout dut%0d: ready=%b required 1", d, req_ready[d]); end
      req_valid[d] = 1'b1; req_addr[d] = a; req_wstrb[d] = s; req_wdata[d] = wd;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      checks++;
      if (req_ready[d] !== 1'b0) begin errors++; $display("FAIL ready_busy dut%0d: got %b required 0", d, req_ready[d]); end
      n = 0;
      while (resp_valid[d] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (n != 1 + wc(d)) begin errors++; $display("FAIL latency dut%0d addr=%h: got %0d required %0d", d, a, n, 1 + wc(d)); end
      checks++;
      if (resp_rdata[d] !== xr) begin errors++; $display("FAIL rdata dut%0d addr=%h strb=%h: got %h required %h", d, a, s, resp_rdata[d], xr); end
      checks++;
      if (resp_err[d] !== xe) begin errors++; $display("FAIL err dut%0d addr=%h strb=%h: got %b required %b", d, a, s, resp_err[d], xe); end
      rd = resp_rdata[d];
      er = resp_err[d];
      @(posedge clk); #1;
      checks++;
      if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
         errors++; $display("FAIL pulse dut%0d: valid=%b ready=%b required 0/1", d, resp_valid[d], req_ready[d]);
      end
   endtask

   task automatic test_reset;
      rst = 2'b11; req_valid = '0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_state dut%0d: valid=%b rdata=%h err=%b ready=%b required 0/0/0/1",
                     d, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d]);
         end
      end
      rst = 2'b00;
   endtask

   task automatic test_fill;
      logic [31:0] rd;
      logic er;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) do_req(d, BASE + 32'(4 * i), 4'hF, $urandom, rd, er);
   endtask

   task automatic test_basic;
      logic [31:0] rd;
      logic er;
      do_req(0, BASE + 32'h10, 4'hF, 32'hAABBCCDD, rd, er);
      do_req(0, BASE + 32'h10, 4'h0, 32'h0, rd, er);
      checks++;
      if (rd !== 32'hAABBCCDD || er !== 1'b0) begin errors++; $display("FAIL word_rd: got %h/%b required aabbccdd/0", rd, er); end
      do_req(0, BASE + 32'h12, 4'b0100, 32'h00EE0000, rd, er);
      do_req(0, BASE + 32'h10, 4'h0, 32'h0, rd, er);
      checks++;
      if (rd !== 32'hAAEECCDD) begin errors++; $display("FAIL byte_merge: got %h required aaeeccdd", rd); end
      do_req(0, BASE + 32'h13, 4'h0, 32'h0, rd, er);
      checks++;
      if (rd !== 32'h000000AA) begin errors++; $display("FAIL offset3_rd: got %h required 000000aa", rd); end
   endtask

   task automatic test_err;
      logic [31:0] rd;
      logic er;
      do_req(0, BASE + 32'h11, 4'hF, 32'h11223344, rd, er);
      do_req(0, BASE + 32'h10, 4'h0, 32'h0, rd, er);
      checks++;
`ifdef DMEM_RESPONDER_ERR_EN
      if (rd !== 32'hAAEECCDD) begin errors++; $display("FAIL misaligned_store: got %h required aaeeccdd", rd); end
`else
      if (rd !== 32'h11223344) begin errors++; $display("FAIL misaligned_store: got %h required 11223344", rd); end
`endif
      do_req(0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0, rd, er);
      checks++;
`ifdef DMEM_RESPONDER_ERR_EN
      if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL out_of_range: got %h/%b required 0/1", rd, er); end
`else
      if (er !== 1'b0 || rd !== mm[0][0]) begin errors++; $display("FAIL out_of_range: got %h/%b required %h/0", rd, er, mm[0][0]); end
`endif
   endtask

   task automatic test_random;
      logic [3:0] strbs [12] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h5};
      logic [31:0] a, rd;
      logic er;
      int r;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            a = r == 0 ? BASE + 32'(4 * DEPTH) + $urandom_range(0, 255)
              : r == 1 ? BASE - $urandom_range(1, 64)
              : BASE + $urandom_range(0, 4 * DEPTH - 1);
            do_req(d, a, strbs[$urandom_range(0, 11)], $urandom, rd, er);
         end
   endtask

   task automatic test_back_to_back;
      logic [31:0] q_exp [$];
      logic [31:0] a, xr, ex;
      logic xe, accepted;
      int acc, resp, last, cyc;
      acc = 0; resp = 0; last = -1; cyc = 0;
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + $urandom_range(0, 3);
      req_valid[1] = 1'b1; req_addr[1] = a; req_wstrb[1] = 4'h0; req_wdata[1] = '0;
      while ((acc < 10 || resp < 10) && cyc < 200) begin
         accepted = req_valid[1] && req_ready[1];
         if (accepted) begin model(1, a, 4'h0, 32'h0, xr, xe); q_exp.push_back(xr); acc++; end
         @(posedge clk); #1;
         cyc++;
         if (accepted) begin
            checks++;
            if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b required 0", req_ready[1]); end
            if (acc == 10) req_valid[1] = 1'b0;
            else begin
               a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + $urandom_range(0, 3);
               req_addr[1] = a;
            end
         end
         if (resp_valid[1] === 1'b1) begin
            resp++;
            checks++;
            if (q_exp.size() == 0) begin errors++; $display("FAIL b2b_extra: got response %0d required none", resp); end
            else begin
               ex = q_exp.pop_front();
               if (resp_rdata[1] !== ex) begin errors++; $display("FAIL b2b_rdata: got %h required %h", resp_rdata[1], ex); end
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 6) begin errors++; $display("FAIL b2b_interval: got %0d required 6", cyc - last); end
            end
            last = cyc;
         end
      end
      checks++;
      if (acc != 10 || resp != 10) begin errors++; $display("FAIL b2b_count: got %0d/%0d required 10/10", acc, resp); end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL b2b_dup: got valid=%b required 0", resp_valid[1]); end
      end
   endtask

   task automatic test_reset_in_wait;
      logic [31:0] a, old, rd;
      logic er;
      a = BASE + 32'h14;
      do_req(1, a, 4'h0, 32'h0, old, er);
      req_valid[1] = 1'b1; req_addr[1] = a; req_wstrb[1] = 4'hF; req_wdata[1] = ~old;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      checks++;
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || resp_rdata[1] !== 32'h0 || resp_err[1] !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_state: valid=%b ready=%b rdata=%h err=%b required 0/1/0/0",
                  resp_valid[1], req_ready[1], resp_rdata[1], resp_err[1]);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL rst_wait_resp: got valid=%b required 0", resp_valid[1]); end
      end
      do_req(1, a, 4'h0, 32'h0, rd, er);
      checks++;
      if (rd !== old) begin errors++; $display("FAIL rst_wait_data: got %h required %h", rd, old); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_basic;
      test_err;
      test_back_to_back;
      test_reset_in_wait;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
